// File: rtl/hpdcache_csr_pkg.sv
// hpdcache_csr_pkg: register map, CTRL layout, reset values and event indices
package hpdcache_csr_pkg;

    localparam int unsigned CSR_CTRL     = 32'h00;
    localparam int unsigned CSR_WBUF_THR = 32'h01;
    localparam int unsigned CSR_CNT_CTRL = 32'h02;
    localparam int unsigned CSR_CNT_BASE = 32'h10;

    localparam int unsigned CTRL_ENABLE                   = 0;
    localparam int unsigned CTRL_RESET_TIMECNT_ON_WRITE   = 1;
    localparam int unsigned CTRL_SEQUENTIAL_WAW           = 2;
    localparam int unsigned CTRL_INHIBIT_WRITE_COALESCING = 3;
    localparam int unsigned CTRL_PREFETCH_UPDT_PLRU       = 4;
    localparam int unsigned CTRL_ERROR_ON_CACHEABLE_AMO   = 5;
    localparam int unsigned CTRL_RTAB_SINGLE_ENTRY        = 6;
    localparam int unsigned CTRL_DEFAULT_WB               = 7;

    localparam logic [7:0]  CTRL_RST     = 8'h13;
    localparam int unsigned WBUF_THR_RST = 2;

    localparam int unsigned CNT_CTRL_FREEZE = 0;
    localparam int unsigned CNT_CTRL_CLEAR  = 1;

    typedef enum int unsigned {
        EVT_WRITE_MISS    = 0,
        EVT_READ_MISS     = 1,
        EVT_UNCACHED      = 2,
        EVT_CMO           = 3,
        EVT_WRITE         = 4,
        EVT_READ          = 5,
        EVT_PREFETCH      = 6,
        EVT_ON_HOLD       = 7,
        EVT_RTAB_ROLLBACK = 8,
        EVT_STALL_REFILL  = 9,
        EVT_STALL         = 10
    } evt_e;

endpackage

// File: rtl/hpdcache_csr_counter.sv
// hpdcache_csr_counter: one event counter with clear, load, freeze and saturate/wrap
module hpdcache_csr_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             freeze,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // Clear beats load beats freeze beats increment; the dropped event is simply lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) value <= '0;
        else if (clear) value <= '0;
        else if (load) value <= load_data;
        else if (inc && !freeze && !(SATURATE && &value)) value <= value + 1'b1;
    end

endmodule

// File: rtl/hpdcache_csr.sv
// hpdcache_csr: software-writable cache configuration and event counters behind a valid/ready CSR port
module hpdcache_csr
    import hpdcache_csr_pkg::*;
#(
    parameter int unsigned NEVT          = 11,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned CNT_SATURATE  = 1,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned TIMECNT_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     csr_req_valid_i,
    output logic                     csr_req_ready_o,
    input  logic                     csr_req_we_i,
    input  logic [ADDR_WIDTH-1:0]    csr_req_addr_i,
    input  logic [DATA_WIDTH-1:0]    csr_req_wdata_i,
    output logic                     csr_rsp_valid_o,
    input  logic                     csr_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]    csr_rsp_rdata_o,
    output logic                     csr_rsp_err_o,
    input  logic [NEVT-1:0]          evt_i,
    output logic                     cfg_enable_o,
    output logic                     cfg_wbuf_reset_timecnt_on_write_o,
    output logic                     cfg_wbuf_sequential_waw_o,
    output logic                     cfg_wbuf_inhibit_write_coalescing_o,
    output logic                     cfg_prefetch_updt_plru_o,
    output logic                     cfg_error_on_cacheable_amo_o,
    output logic                     cfg_rtab_single_entry_o,
    output logic                     cfg_default_wb_o,
    output logic [TIMECNT_WIDTH-1:0] cfg_wbuf_threshold_o
);

    logic                     accept;
    logic                     wr;
    logic                     clear;
    logic                     hit_ctrl;
    logic                     hit_thr;
    logic                     hit_cc;
    logic [NEVT-1:0]          hit_cnt;
    logic                     rd_err;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [DATA_WIDTH-1:0]    cnt_rd;
    logic [7:0]               ctrl;
    logic [TIMECNT_WIDTH-1:0] thr;
    logic                     freeze;
    logic                     rsp_valid;
    logic [CNT_WIDTH-1:0]     cnt [NEVT];
    logic                     unused_wdata;

    assign csr_req_ready_o = !rsp_valid || csr_rsp_ready_i;
    assign csr_rsp_valid_o = rsp_valid;
    assign accept          = csr_req_valid_i && csr_req_ready_o;
    assign wr              = accept && csr_req_we_i;
    assign hit_ctrl        = csr_req_addr_i == ADDR_WIDTH'(CSR_CTRL);
    assign hit_thr         = csr_req_addr_i == ADDR_WIDTH'(CSR_WBUF_THR);
    assign hit_cc          = csr_req_addr_i == ADDR_WIDTH'(CSR_CNT_CTRL);
    assign clear           = wr && hit_cc && csr_req_wdata_i[CNT_CTRL_CLEAR];
    assign unused_wdata    = ^csr_req_wdata_i;

    for (genvar i = 0; i < NEVT; i++) begin : g_cnt
        assign hit_cnt[i] = csr_req_addr_i == ADDR_WIDTH'(CSR_CNT_BASE + i);
        hpdcache_csr_counter #(
            .WIDTH    (CNT_WIDTH),
            .SATURATE (CNT_SATURATE != 0)
        ) u_counter (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear     (clear),
            .load      (wr && hit_cnt[i]),
            .load_data (csr_req_wdata_i[CNT_WIDTH-1:0]),
            .freeze    (freeze),
            .inc       (evt_i[i]),
            .value     (cnt[i])
        );
    end

    // Counter read mux; at most one hit bit is set for a given address
    always_comb begin
        cnt_rd = '0;
        for (int unsigned i = 0; i < NEVT; i++)
            if (hit_cnt[i]) cnt_rd = DATA_WIDTH'(cnt[i]);
    end

    assign rd_data = hit_ctrl ? DATA_WIDTH'(ctrl)
                   : hit_thr  ? DATA_WIDTH'(thr)
                   : hit_cc   ? DATA_WIDTH'(freeze)
                   : cnt_rd;
    assign rd_err  = !(hit_ctrl || hit_thr || hit_cc || |hit_cnt);

    // Single response slot, loaded on acceptance and held until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid       <= 1'b0;
            csr_rsp_rdata_o <= '0;
            csr_rsp_err_o   <= 1'b0;
        end else if (accept) begin
            rsp_valid       <= 1'b1;
            csr_rsp_rdata_o <= csr_req_we_i ? '0 : rd_data;
            csr_rsp_err_o   <= rd_err;
        end else if (csr_rsp_ready_i) begin
            rsp_valid       <= 1'b0;
        end
    end

    // Configuration registers; freeze is registered so it gates increments from the next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl   <= CTRL_RST;
            thr    <= TIMECNT_WIDTH'(WBUF_THR_RST);
            freeze <= 1'b0;
        end else if (wr) begin
            if (hit_ctrl) ctrl <= csr_req_wdata_i[7:0];
            if (hit_thr) thr <= csr_req_wdata_i[TIMECNT_WIDTH-1:0];
            if (hit_cc) freeze <= csr_req_wdata_i[CNT_CTRL_FREEZE];
        end
    end

    assign cfg_enable_o                        = ctrl[CTRL_ENABLE];
    assign cfg_wbuf_reset_timecnt_on_write_o   = ctrl[CTRL_RESET_TIMECNT_ON_WRITE];
    assign cfg_wbuf_sequential_waw_o           = ctrl[CTRL_SEQUENTIAL_WAW];
    assign cfg_wbuf_inhibit_write_coalescing_o = ctrl[CTRL_INHIBIT_WRITE_COALESCING];
    assign cfg_prefetch_updt_plru_o            = ctrl[CTRL_PREFETCH_UPDT_PLRU];
    assign cfg_error_on_cacheable_amo_o        = ctrl[CTRL_ERROR_ON_CACHEABLE_AMO];
    assign cfg_rtab_single_entry_o             = ctrl[CTRL_RTAB_SINGLE_ENTRY];
    assign cfg_default_wb_o                    = ctrl[CTRL_DEFAULT_WB];
    assign cfg_wbuf_threshold_o                = thr;

endmodule
